mem_wb_stage: RTL and testbench

//  Consumer end of the EX/MEM pipeline register. Takes the EX/MEM control bits,
//  ALU result, store data and rd; runs the load/store on data memory through a
//  req/ack handshake; holds the upstream pipeline while an access is in flight.

---
 rtl/mem_wb_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: runs loads/stores on data memory over a req/ack handshake,
// stalls upstream while an access is in flight, and registers the write-back bundle.
module mem_wb_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic        inWord,
  input  logic        inRegWrite,
  input  logic [31:0] inResult,
  input  logic [31:0] inWriteData,
  input  logic [4:0]  inRd,
  output logic        outMemReq,
  output logic        outMemWe,
  output logic [31:0] outMemAddr,
  output logic [31:0] outMemWData,
  output logic [3:0]  outMemBe,
  input  logic        inMemAck,
  input  logic [31:0] inMemRData,
  output logic        outStall,
  output logic        outMemErr,
  output logic        outRegWrite,
  output logic [4:0]  outRd,
  output logic [31:0] outWbData
);

  // state  | meaning
  // IDLE   | pass-through of non-memory ops; issues new accesses
  // ACCESS | request outstanding, upstream held, wait counter running

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_wait_cnt;
  logic            r_mem_req, r_mem_we, r_mem_err, r_reg_write;
  logic [31:0]     r_mem_addr, r_mem_wdata, r_wb_data;
  logic [3:0]      r_mem_be;
  logic [4:0]      r_rd;
  logic [4:0]      r_lat_rd;
  logic            r_lat_regwrite, r_lat_load, r_lat_word;
  logic [1:0]      r_lat_lane;

  logic            w_issue, w_err, w_ack_done, w_abort;
  logic            w_is_mem, w_misalign, w_both;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [7:0]      w_rbyte;
  logic [31:0]     w_load_data;

  assign w_is_mem   = inMemRead | inMemWrite;
  assign w_both     = inMemRead & inMemWrite;
  assign w_misalign = inWord & (inResult[1:0] != 2'b00);
  assign w_be       = inWord ? 4'hF : (4'b0001 << inResult[1:0]);
  assign w_wdata    = inWord ? inWriteData : {4{inWriteData[7:0]}};

  always_comb begin
    w_rbyte = inMemRData[7:0];
    case (r_lat_lane)
      2'd0: w_rbyte = inMemRData[7:0];
      2'd1: w_rbyte = inMemRData[15:8];
      2'd2: w_rbyte = inMemRData[23:16];
      2'd3: w_rbyte = inMemRData[31:24];
      default: w_rbyte = inMemRData[7:0];
    endcase
  end

  assign w_load_data = r_lat_word ? inMemRData : {24'b0, w_rbyte};

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_err       = 1'b0;
    w_ack_done  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_both || (w_is_mem && w_misalign)) begin
          w_err = 1'b1;
        end else if (w_is_mem) begin
          w_issue     = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // an ack on the timeout edge takes priority over the abort
        if (inMemAck) begin
          w_ack_done  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_wait_cnt == CW'(MAX_WAIT - 1)) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state        <= IDLE;
      r_wait_cnt     <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_be       <= '0;
      r_mem_err      <= 1'b0;
      r_reg_write    <= 1'b0;
      r_rd           <= '0;
      r_wb_data      <= '0;
      r_lat_rd       <= '0;
      r_lat_regwrite <= 1'b0;
      r_lat_load     <= 1'b0;
      r_lat_word     <= 1'b0;
      r_lat_lane     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_err <= w_err | w_abort;
      if (r_state == IDLE) begin
        r_wait_cnt <= '0;
        if (w_issue) begin
          r_lat_rd       <= inRd;
          r_lat_regwrite <= inRegWrite;
          r_lat_load     <= inMemRead;
          r_lat_word     <= inWord;
          r_lat_lane     <= inResult[1:0];
          r_mem_req      <= 1'b1;
          r_mem_we       <= inMemWrite;
          r_mem_addr     <= {inResult[31:2], 2'b00};
          r_mem_wdata    <= w_wdata;
          r_mem_be       <= w_be;
          r_reg_write    <= 1'b0;
        end else if (w_err) begin
          r_reg_write <= 1'b0;
        end else begin
          r_reg_write <= inRegWrite;
          r_rd        <= inRd;
          r_wb_data   <= inResult;
        end
      end else begin
        if (w_ack_done) begin
          r_mem_req  <= 1'b0;
          r_wait_cnt <= '0;
          if (r_lat_load) begin
            r_reg_write <= r_lat_regwrite;
            r_rd        <= r_lat_rd;
            r_wb_data   <= w_load_data;
          end else begin
            r_reg_write <= 1'b0;
          end
        end else if (w_abort) begin
          r_mem_req   <= 1'b0;
          r_wait_cnt  <= '0;
          r_reg_write <= 1'b0;
        end else begin
          r_wait_cnt <= r_wait_cnt + CW'(1);
        end
      end
    end
  end

  assign outStall    = (r_state == ACCESS);
  assign outMemReq   = r_mem_req;
  assign outMemWe    = r_mem_we;
  assign outMemAddr  = r_mem_addr;
  assign outMemWData = r_mem_wdata;
  assign outMemBe    = r_mem_be;
  assign outMemErr   = r_mem_err;
  assign outRegWrite = r_reg_write;
  assign outRd       = r_rd;
  assign outWbData   = r_wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: pass-through, loads/stores, alignment errors,
// timeout abort, ack-at-timeout priority and reset during an access.
module tb_mem_wb_stage;
  logic        clock = 1'b0;
  logic        resetN;
  logic        inMemRead, inMemWrite, inWord, inRegWrite;
  logic [31:0] inResult, inWriteData;
  logic [4:0]  inRd;
  logic        outMemReq, outMemWe;
  logic [31:0] outMemAddr, outMemWData;
  logic [3:0]  outMemBe;
  logic        inMemAck;
  logic [31:0] inMemRData;
  logic        outStall, outMemErr, outRegWrite;
  logic [4:0]  outRd;
  logic [31:0] outWbData;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;
  int err_seen;

  mem_wb_stage #(.MAX_WAIT(255)) dut (
    .clock(clock), .resetN(resetN),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inWord(inWord),
    .inRegWrite(inRegWrite), .inResult(inResult), .inWriteData(inWriteData),
    .inRd(inRd), .outMemReq(outMemReq), .outMemWe(outMemWe),
    .outMemAddr(outMemAddr), .outMemWData(outMemWData), .outMemBe(outMemBe),
    .inMemAck(inMemAck), .inMemRData(inMemRData), .outStall(outStall),
    .outMemErr(outMemErr), .outRegWrite(outRegWrite), .outRd(outRd),
    .outWbData(outWbData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic rd_op, input logic wr_op, input logic word,
                        input logic rw, input logic [31:0] res,
                        input logic [31:0] wd, input logic [4:0] rd);
    inMemRead   = rd_op;
    inMemWrite  = wr_op;
    inWord      = word;
    inRegWrite  = rw;
    inResult    = res;
    inWriteData = wd;
    inRd        = rd;
  endtask

  initial begin
    resetN = 1'b0;
    inMemAck = 1'b0;
    inMemRData = '0;
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    step(); step();
    check("rst_req",   32'(outMemReq), 32'd0);
    check("rst_stall", 32'(outStall), 32'd0);
    check("rst_err",   32'(outMemErr), 32'd0);
    check("rst_rw",    32'(outRegWrite), 32'd0);
    check("rst_wb",    outWbData, 32'h0);

    // non-memory pass-through
    resetN = 1'b1;
    set_op(0, 0, 0, 1, 32'h1234, 32'h0, 5'd5);
    step();
    check("alu_wb",    outWbData, 32'h1234);
    check("alu_rd",    32'(outRd), 32'd5);
    check("alu_rw",    32'(outRegWrite), 32'd1);
    check("alu_stall", 32'(outStall), 32'd0);

    // word load at 0x100, three stall cycles, then held ALU op consumed
    set_op(1, 0, 1, 1, 32'h100, 32'h0, 5'd7);
    step();
    check("wl_req",  32'(outMemReq), 32'd1);
    check("wl_we",   32'(outMemWe), 32'd0);
    check("wl_addr", outMemAddr, 32'h100);
    check("wl_be",   32'(outMemBe), 32'hF);
    check("wl_rw0",  32'(outRegWrite), 32'd0);
    set_op(0, 0, 0, 1, 32'h55, 32'h0, 5'd9);
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (outStall) stall_cnt++;
      if (i < 2) step();
    end
    check("wl_stall3", 32'(stall_cnt), 32'd3);
    inMemAck = 1'b1;
    inMemRData = 32'hDEADBEEF;
    step();
    inMemAck = 1'b0;
    check("wl_req0",  32'(outMemReq), 32'd0);
    check("wl_stall", 32'(outStall), 32'd0);
    check("wl_wb",    outWbData, 32'hDEADBEEF);
    check("wl_rd",    32'(outRd), 32'd7);
    check("wl_rw",    32'(outRegWrite), 32'd1);
    step();
    check("held_wb", outWbData, 32'h55);
    check("held_rd", 32'(outRd), 32'd9);

    // byte store at 0x103
    set_op(0, 1, 0, 1, 32'h103, 32'h5A, 5'd4);
    step();
    check("bs_req",   32'(outMemReq), 32'd1);
    check("bs_we",    32'(outMemWe), 32'd1);
    check("bs_addr",  outMemAddr, 32'h100);
    check("bs_be",    32'(outMemBe), 32'h8);
    check("bs_wdata", outMemWData, 32'h5A5A5A5A);
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    inMemAck = 1'b1;
    step();
    inMemAck = 1'b0;
    check("bs_rw",    32'(outRegWrite), 32'd0);
    check("bs_req0",  32'(outMemReq), 32'd0);

    // byte load at address 2
    set_op(1, 0, 0, 1, 32'h2, 32'h0, 5'd3);
    step();
    check("bl_be",   32'(outMemBe), 32'h4);
    check("bl_addr", outMemAddr, 32'h0);
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    inMemAck = 1'b1;
    inMemRData = 32'h11223344;
    step();
    inMemAck = 1'b0;
    check("bl_wb", outWbData, 32'h00000022);
    check("bl_rw", 32'(outRegWrite), 32'd1);
    check("bl_rd", 32'(outRd), 32'd3);

    // timeout: no ack
    set_op(1, 0, 1, 1, 32'h200, 32'h0, 5'd6);
    step();
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    stall_cnt = 0;
    err_seen = 0;
    for (int i = 0; i < 400; i++) begin
      if (!outStall) break;
      stall_cnt++;
      if (outMemErr) err_seen++;
      step();
    end
    check("to_stall_len", 32'(stall_cnt), 32'd255);
    check("to_err_early", 32'(err_seen), 32'd0);
    check("to_err",       32'(outMemErr), 32'd1);
    check("to_req0",      32'(outMemReq), 32'd0);
    check("to_rw",        32'(outRegWrite), 32'd0);
    step();
    check("to_err_pulse", 32'(outMemErr), 32'd0);

    // misaligned word load
    set_op(1, 0, 1, 1, 32'h102, 32'h0, 5'd8);
    step();
    check("mis_err",   32'(outMemErr), 32'd1);
    check("mis_req",   32'(outMemReq), 32'd0);
    check("mis_stall", 32'(outStall), 32'd0);
    check("mis_rw",    32'(outRegWrite), 32'd0);
    set_op(1, 1, 0, 1, 32'h0, 32'h0, 5'd8);
    step();
    check("both_err", 32'(outMemErr), 32'd1);
    check("both_req", 32'(outMemReq), 32'd0);
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    step();
    check("err_clear", 32'(outMemErr), 32'd0);

    // ack on the timeout edge wins
    set_op(1, 0, 1, 1, 32'h400, 32'h0, 5'd10);
    step();
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 254; i++) step();
    check("edge_stall", 32'(outStall), 32'd1);
    inMemAck = 1'b1;
    inMemRData = 32'hCAFEF00D;
    step();
    inMemAck = 1'b0;
    check("edge_err",   32'(outMemErr), 32'd0);
    check("edge_wb",    outWbData, 32'hCAFEF00D);
    check("edge_rw",    32'(outRegWrite), 32'd1);
    check("edge_stall0", 32'(outStall), 32'd0);

    // reset during access, late ack ignored
    set_op(1, 0, 1, 1, 32'h300, 32'h0, 5'd11);
    step();
    check("ra_req", 32'(outMemReq), 32'd1);
    resetN = 1'b0;
    set_op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    step();
    check("ra_req0",  32'(outMemReq), 32'd0);
    check("ra_stall", 32'(outStall), 32'd0);
    resetN = 1'b1;
    inMemAck = 1'b1;
    inMemRData = 32'h87654321;
    step();
    inMemAck = 1'b0;
    check("late_rw",  32'(outRegWrite), 32'd0);
    check("late_wb",  outWbData, 32'h0);
    check("late_req", 32'(outMemReq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
